// File: rtl/hw_trig_stretcher_if.sv
`default_nettype none
// ============================================================================
//  Module      : hw_trig_stretcher_if
//  Description : Bundle of trigger inputs, shared controls and stretched
//                outputs exchanged between fast logic and hw_trig_stretcher.
//  Revision    : 1.0 - initial release
// ============================================================================
interface hw_trig_stretcher_if #(
  parameter int NCH    = 4,
  parameter int LEN_W  = 8,
  parameter int MISS_W = 16
);
  logic              wLClk_i;
  logic [NCH-1:0]    wTrig_i;
  logic [LEN_W-1:0]  wLen_i;
  logic              wRetrig_i;
  logic              wMissClr_i;
  logic [NCH-1:0]    wTrig_o;
  logic              wBusy_o;
  logic [NCH-1:0]    wMiss_o;
  logic [MISS_W-1:0] wMissCnt_o;

  // Trigger source side: drives triggers and controls, observes results
  modport master (
    output wLClk_i, wTrig_i, wLen_i, wRetrig_i, wMissClr_i,
    input  wTrig_o, wBusy_o, wMiss_o, wMissCnt_o
  );

  // Stretcher side
  modport slave (
    input  wLClk_i, wTrig_i, wLen_i, wRetrig_i, wMissClr_i,
    output wTrig_o, wBusy_o, wMiss_o, wMissCnt_o
  );
endinterface
`default_nettype wire

// File: rtl/hw_trig_stretcher.sv
`default_nettype none
// ============================================================================
//  Module      : hw_trig_stretcher
//  Description : NCH-channel short-to-long trigger stretcher. Each channel
//                holds its output for L slow-reference periods (L = wLen_i,
//                0 treated as 1), with retrigger/drop handling and per-channel
//                missed-trigger pulses. The slow reference is sampled as data.
//                Optional macro HWTRIG_MISSCNT_EN adds a saturating counter of
//                dropped triggers; without it wMissCnt_o is tied to zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module hw_trig_stretcher #(
  parameter int NCH    = 4,
  parameter int LEN_W  = 8,
  parameter int MISS_W = 16
) (
  input  wire logic           wClk_i,
  input  wire logic           wReset_i,
  hw_trig_stretcher_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  localparam logic [LEN_W-1:0] C_LEN_ONE = LEN_W'(1);

  state_t           state_q [NCH];
  logic [LEN_W-1:0] len_q   [NCH];
  logic [LEN_W-1:0] cnt_q   [NCH];
  logic [2:0]       sync_q;
  logic             busy_q;
  logic [NCH-1:0]   miss_q;

  logic             w_lEdge;
  logic [LEN_W-1:0] w_lenEff;
  logic [NCH-1:0]   w_active;
  logic [NCH-1:0]   w_drop;

  // Rising edge of the slow reference, seen two flops after the sampler
  assign w_lEdge  = sync_q[1] & ~sync_q[2];
  assign w_lenEff = (bus.wLen_i == '0) ? C_LEN_ONE : bus.wLen_i;

  // Per-channel busy flag and triggers dropped because the channel is busy
  always_comb begin
    w_active = '0;
    w_drop   = '0;
    for (int c = 0; c < NCH; c++) begin
      w_active[c] = (state_q[c] != ST_IDLE);
      w_drop[c]   = bus.wTrig_i[c] & w_active[c] & ~bus.wRetrig_i;
    end
  end

  // Sample the slow reference into a three-flop chain
  always_ff @(posedge wClk_i or posedge wReset_i) begin
    if (wReset_i) sync_q <= 3'b000;
    else          sync_q <= {sync_q[1:0], bus.wLClk_i};
  end

  // Channel FSMs; a retrigger takes precedence over a coincident slow edge
  always_ff @(posedge wClk_i or posedge wReset_i) begin
    if (wReset_i) begin
      for (int c = 0; c < NCH; c++) begin
        state_q[c] <= ST_IDLE;
        len_q[c]   <= '0;
        cnt_q[c]   <= '0;
      end
    end else begin
      for (int c = 0; c < NCH; c++) begin
        case (state_q[c])
          ST_IDLE: begin
            // Accept; a coincident slow edge is deliberately not counted
            if (bus.wTrig_i[c]) begin
              state_q[c] <= ST_ARM;
              len_q[c]   <= w_lenEff;
            end
          end
          ST_ARM: begin
            if (bus.wTrig_i[c] && bus.wRetrig_i) begin
              len_q[c] <= w_lenEff;
            end else if (w_lEdge) begin
              state_q[c] <= ST_HOLD;
              cnt_q[c]   <= len_q[c];
            end
          end
          ST_HOLD: begin
            if (bus.wTrig_i[c] && bus.wRetrig_i) begin
              state_q[c] <= ST_ARM;
              len_q[c]   <= w_lenEff;
            end else if (w_lEdge) begin
              if (cnt_q[c] == C_LEN_ONE) state_q[c] <= ST_IDLE;
              cnt_q[c] <= cnt_q[c] - C_LEN_ONE;
            end
          end
          default: state_q[c] <= ST_IDLE;
        endcase
      end
    end
  end

  // Registered status: busy summary and one-cycle miss pulses
  always_ff @(posedge wClk_i or posedge wReset_i) begin
    if (wReset_i) begin
      busy_q <= 1'b0;
      miss_q <= '0;
    end else begin
      busy_q <= |w_active;
      miss_q <= w_drop;
    end
  end

`ifdef HWTRIG_MISSCNT_EN
  localparam int POP_W = $clog2(NCH + 1);
  localparam int SUM_W = MISS_W + POP_W;

  logic [POP_W-1:0]  w_pop;
  logic [SUM_W-1:0]  w_sum;
  logic [MISS_W-1:0] missCnt_d;
  logic [MISS_W-1:0] missCnt_q;

  // Add this cycle's dropped triggers, saturating; clear wins over increment
  always_comb begin
    w_pop = '0;
    for (int c = 0; c < NCH; c++) w_pop = w_pop + POP_W'(w_drop[c]);
    w_sum = SUM_W'(missCnt_q) + SUM_W'(w_pop);
    if (bus.wMissClr_i)                          missCnt_d = '0;
    else if (w_sum > SUM_W'({MISS_W{1'b1}}))     missCnt_d = '1;
    else                                         missCnt_d = w_sum[MISS_W-1:0];
  end

  // Miss counter register
  always_ff @(posedge wClk_i or posedge wReset_i) begin
    if (wReset_i) missCnt_q <= '0;
    else          missCnt_q <= missCnt_d;
  end

  assign bus.wMissCnt_o = missCnt_q;
`else
  assign bus.wMissCnt_o = '0;
`endif

  // Output rises combinationally with the trigger, then held by the FSM
  assign bus.wTrig_o = bus.wTrig_i | w_active;
  assign bus.wBusy_o = busy_q;
  assign bus.wMiss_o = miss_q;

endmodule
`default_nettype wire

// File: tb/tb_hw_trig_stretcher.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hw_trig_stretcher
//  Description : Directed self-checking bench for hw_trig_stretcher
//                (NCH=4, LEN_W=8, MISS_W=4). The slow reference is driven
//                at fast/8 by hand so every slow edge lands on a known cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hw_trig_stretcher;

  localparam int NCH    = 4;
  localparam int LEN_W  = 8;
  localparam int MISS_W = 4;
`ifdef HWTRIG_MISSCNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  hw_trig_stretcher_if #(.NCH(NCH), .LEN_W(LEN_W), .MISS_W(MISS_W)) bus();

  hw_trig_stretcher #(.NCH(NCH), .LEN_W(LEN_W), .MISS_W(MISS_W)) dut (
    .wClk_i   (clk),
    .wReset_i (rst),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [MISS_W-1:0] exp_cnt(input int v);
    return CNT_EN ? MISS_W'(v) : '0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.wTrig_i    = '0;
    bus.wLClk_i    = 1'b0;
    bus.wMissClr_i = 1'b0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  // One full slow period: high 4 cycles (edge acts on the 3rd), low 4 cycles
  task automatic slow_edge();
    bus.wLClk_i = 1'b1;
    repeat (4) step();
    bus.wLClk_i = 1'b0;
    repeat (4) step();
  endtask

  // Slow period that must end channel ch's window exactly on the acting edge
  task automatic final_edge(input int ch, input string nm);
    bus.wLClk_i = 1'b1;
    step();
    step();
    checks++;
    if (bus.wTrig_o[ch] !== 1'b1) begin
      failures++;
      $display("FAIL %s_before: got %b expected 1", nm, bus.wTrig_o[ch]);
    end
    step();
    checks++;
    if (bus.wTrig_o[ch] !== 1'b0) begin
      failures++;
      $display("FAIL %s_fall: got %b expected 0", nm, bus.wTrig_o[ch]);
    end
    step();
    bus.wLClk_i = 1'b0;
    repeat (4) step();
  endtask

  task automatic test_reset();
    bus.wTrig_i = 4'b1010;
    rst = 1'b1;
    step();
    checks++;
    if (bus.wTrig_o !== 4'b1010 || bus.wBusy_o !== 1'b0 || bus.wMiss_o !== 4'b0000 ||
        bus.wMissCnt_o !== '0) begin
      failures++;
      $display("FAIL reset_state: got trig=%b busy=%b miss=%b cnt=%0d expected 1010 0 0000 0",
               bus.wTrig_o, bus.wBusy_o, bus.wMiss_o, bus.wMissCnt_o);
    end
    do_reset();
  endtask

  task automatic test_legacy();
    do_reset();
    bus.wLen_i = 8'd1;
    bus.wRetrig_i = 1'b0;
    bus.wTrig_i = 4'b0001;
    #1;
    checks++;
    if (bus.wTrig_o !== 4'b0001) begin
      failures++;
      $display("FAIL legacy_rise: got %b expected 0001", bus.wTrig_o);
    end
    step();
    bus.wTrig_i = 4'b0000;
    #1;
    checks++;
    if (bus.wTrig_o !== 4'b0001) begin
      failures++;
      $display("FAIL legacy_hold: got %b expected 0001", bus.wTrig_o);
    end
    slow_edge();
    checks++;
    if (bus.wBusy_o !== 1'b1) begin
      failures++;
      $display("FAIL legacy_busy: got %b expected 1", bus.wBusy_o);
    end
    final_edge(0, "legacy");
  endtask

  task automatic test_length();
    do_reset();
    bus.wLen_i = 8'd5;
    bus.wTrig_i = 4'b0100;
    step();
    bus.wTrig_i = 4'b0000;
    for (int i = 0; i < 5; i++) begin
      slow_edge();
      checks++;
      if (bus.wTrig_o !== 4'b0100) begin
        failures++;
        $display("FAIL len5_edge%0d: got %b expected 0100", i + 1, bus.wTrig_o);
      end
    end
    final_edge(2, "len5");
    bus.wLen_i = 8'd0;
    bus.wTrig_i = 4'b0010;
    step();
    bus.wTrig_i = 4'b0000;
    slow_edge();
    checks++;
    if (bus.wTrig_o !== 4'b0010) begin
      failures++;
      $display("FAIL len0_hold: got %b expected 0010", bus.wTrig_o);
    end
    final_edge(1, "len0");
  endtask

  task automatic test_drop();
    do_reset();
    bus.wLen_i = 8'd3;
    bus.wRetrig_i = 1'b0;
    bus.wTrig_i = 4'b0001;
    step();
    bus.wTrig_i = 4'b0000;
    slow_edge();
    slow_edge();
    bus.wTrig_i = 4'b0001;
    step();
    bus.wTrig_i = 4'b0000;
    #1;
    checks++;
    if (bus.wMiss_o !== 4'b0001 || bus.wMissCnt_o !== exp_cnt(1)) begin
      failures++;
      $display("FAIL drop_miss: got miss=%b cnt=%0d expected 0001 %0d",
               bus.wMiss_o, bus.wMissCnt_o, exp_cnt(1));
    end
    step();
    checks++;
    if (bus.wMiss_o !== 4'b0000) begin
      failures++;
      $display("FAIL drop_pulse_width: got %b expected 0000", bus.wMiss_o);
    end
    bus.wTrig_i = 4'b1110;
    step();
    step();
    bus.wTrig_i = 4'b0000;
    #1;
    checks++;
    if (bus.wMiss_o !== 4'b1110 || bus.wMissCnt_o !== exp_cnt(4)) begin
      failures++;
      $display("FAIL drop_multi: got miss=%b cnt=%0d expected 1110 %0d",
               bus.wMiss_o, bus.wMissCnt_o, exp_cnt(4));
    end
    slow_edge();
    final_edge(0, "drop_end");
    checks++;
    if (bus.wTrig_o !== 4'b1110) begin
      failures++;
      $display("FAIL drop_others: got %b expected 1110", bus.wTrig_o);
    end
  endtask

  task automatic test_retrigger();
    do_reset();
    bus.wLen_i = 8'd3;
    bus.wRetrig_i = 1'b1;
    bus.wTrig_i = 4'b0001;
    step();
    bus.wTrig_i = 4'b0000;
    slow_edge();
    slow_edge();
    bus.wTrig_i = 4'b0001;
    step();
    bus.wTrig_i = 4'b0000;
    #1;
    checks++;
    if (bus.wMiss_o !== 4'b0000) begin
      failures++;
      $display("FAIL retrig_nomiss: got %b expected 0000", bus.wMiss_o);
    end
    for (int i = 0; i < 3; i++) begin
      slow_edge();
      checks++;
      if (bus.wTrig_o[0] !== 1'b1) begin
        failures++;
        $display("FAIL retrig_extend%0d: got %b expected 1", i + 1, bus.wTrig_o[0]);
      end
    end
    final_edge(0, "retrig_end");
    checks++;
    if (bus.wMissCnt_o !== '0) begin
      failures++;
      $display("FAIL retrig_cnt: got %0d expected 0", bus.wMissCnt_o);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    bus.wLen_i = 8'd1;
    bus.wRetrig_i = 1'b0;
    bus.wTrig_i = 4'b0001;
    step();
    repeat (14) step();
    checks++;
    if (bus.wMissCnt_o !== exp_cnt(14) || bus.wMiss_o !== 4'b0001) begin
      failures++;
      $display("FAIL sat_14: got cnt=%0d miss=%b expected %0d 0001",
               bus.wMissCnt_o, bus.wMiss_o, exp_cnt(14));
    end
    repeat (6) step();
    checks++;
    if (bus.wMissCnt_o !== exp_cnt(15)) begin
      failures++;
      $display("FAIL sat_hold: got %0d expected %0d", bus.wMissCnt_o, exp_cnt(15));
    end
    bus.wMissClr_i = 1'b1;
    step();
    bus.wMissClr_i = 1'b0;
    bus.wTrig_i = 4'b0000;
    #1;
    checks++;
    if (bus.wMissCnt_o !== '0) begin
      failures++;
      $display("FAIL clr_with_miss: got %0d expected 0", bus.wMissCnt_o);
    end
  endtask

  task automatic test_coincident(input logic retrig);
    do_reset();
    bus.wLen_i = 8'd1;
    bus.wRetrig_i = retrig;
    bus.wTrig_i = 4'b0001;
    step();
    bus.wTrig_i = 4'b0000;
    slow_edge();
    bus.wLClk_i = 1'b1;
    step();
    step();
    bus.wTrig_i = 4'b0001;
    step();
    bus.wTrig_i = 4'b0000;
    #1;
    checks++;
    if (bus.wTrig_o[0] !== retrig || bus.wMiss_o[0] !== ~retrig ||
        bus.wMissCnt_o !== exp_cnt(retrig ? 0 : 1)) begin
      failures++;
      $display("FAIL coinc_r%0d: got trig=%b miss=%b cnt=%0d expected %b %b %0d", retrig,
               bus.wTrig_o[0], bus.wMiss_o[0], bus.wMissCnt_o, retrig, ~retrig,
               exp_cnt(retrig ? 0 : 1));
    end
    bus.wLClk_i = 1'b0;
    repeat (4) step();
    if (retrig) begin
      slow_edge();
      final_edge(0, "coinc_rearm");
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    bus.wLen_i = 8'd2;
    bus.wRetrig_i = 1'b0;
    bus.wTrig_i = 4'b0001;
    step();
    bus.wTrig_i = 4'b0000;
    slow_edge();
    checks++;
    if (bus.wBusy_o !== 1'b1) begin
      failures++;
      $display("FAIL rst_pre_busy: got %b expected 1", bus.wBusy_o);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.wTrig_o !== 4'b0000 || bus.wBusy_o !== 1'b0) begin
      failures++;
      $display("FAIL rst_async: got trig=%b busy=%b expected 0000 0", bus.wTrig_o, bus.wBusy_o);
    end
    step();
    rst = 1'b0;
    step();
    bus.wTrig_i = 4'b0001;
    step();
    bus.wTrig_i = 4'b0000;
    #1;
    checks++;
    if (bus.wTrig_o !== 4'b0001) begin
      failures++;
      $display("FAIL rst_reaccept: got %b expected 0001", bus.wTrig_o);
    end
    step();
    checks++;
    if (bus.wBusy_o !== 1'b1) begin
      failures++;
      $display("FAIL rst_reaccept_busy: got %b expected 1", bus.wBusy_o);
    end
  endtask

  initial begin
    bus.wLClk_i    = 1'b0;
    bus.wTrig_i    = '0;
    bus.wLen_i     = 8'd1;
    bus.wRetrig_i  = 1'b0;
    bus.wMissClr_i = 1'b0;
    test_reset();
    test_legacy();
    test_length();
    test_drop();
    test_retrigger();
    test_saturation();
    test_coincident(1'b0);
    test_coincident(1'b1);
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hw_trig_stretcher.md
# hw_trig_stretcher

Multi-channel successor to the single-channel short-to-long trigger converter. Each of NCH channels captures a short trigger pulse from fast logic and holds its output high for a programmable number of slow-reference periods, so slowly clocked hardware modules cannot miss it. The block runs entirely in the fast clock domain and samples the slow reference as data. It adds retrigger mode, missed-trigger reporting and an optional saturating miss counter.

## Interface
- NCH, 4, number of independent trigger channels (1..32)
- LEN_W, 8, width of the stretch-length input
- MISS_W, 16, width of the miss counter
- wClk_i  in  1  fast clock; must be faster than 2x the wLClk_i frequency
- wReset_i  in  1  reset, asynchronous, active-high
- wLClk_i  in  1  slow reference clock, sampled as data
- wTrig_i  in  NCH  short trigger per channel, active-high, any width ≥1 cycle
- wLen_i  in  LEN_W  stretch length in slow periods, shared by all channels; sampled at trigger acceptance
- wRetrig_i  in  1  1 = a trigger while busy restarts the window; 0 = a trigger while busy is dropped
- wMissClr_i  in  1  synchronous clear of the miss counter
- wTrig_o  out  NCH  stretched trigger per channel
- wBusy_o  out  1  OR of all channel states != IDLE (registered)
- wMiss_o  out  NCH  one-cycle pulse per dropped trigger (registered)
- wMissCnt_o  out  MISS_W  saturating count of dropped triggers

## Operation
- Slow-edge detect: 3-flop chain rSync[0..2] on wLClk_i; wLEdge = rSync[1] & ~rSync[2]. This edge is shared by all channels.
- Effective length L = wLen_i, with 0 treated as 1. It is latched per channel into rLen at acceptance.
- Per-channel FSM:
  - IDLE: if wTrig_i[c], go to ARM and latch L.
  - ARM (waiting for the first slow edge): on wLEdge, go to HOLD with rCnt = rLen.
  - HOLD: on wLEdge, decrement rCnt. If rCnt == 1 at that edge, go to IDLE.
  - Encoding is 2 bits. The unused code returns to IDLE.
- wTrig_o[c] = wTrig_i[c] | (state != IDLE). This path is combinational, so the output rises in the same cycle as the input.
- With L = 1, behaviour matches the legacy converter: the output spans the trigger plus one complete slow period.
- Trigger in ARM or HOLD:
  - wRetrig_i = 1: go to ARM, relatch L, no miss.
  - wRetrig_i = 0: state is unchanged, and wMiss_o[c] pulses in the next cycle.
- A continuously high wTrig_i counts as one trigger per cycle while busy. Upstream logic must pulse it.
- Miss counter:
  - Each cycle it adds the popcount of the dropped triggers and saturates at all-ones.
  - wMissClr_i takes priority over the increment; the cycle's misses are discarded.

## Timing
- Reset values:
  - All states IDLE.
  - rSync = 0.
  - wBusy_o = 0, wMiss_o = 0, wMissCnt_o = 0.
  - wTrig_o = wTrig_i (pass-through).
- Reset asserted mid-window: the channel drops to IDLE immediately and asynchronously, and wTrig_o falls to wTrig_i.
- Edge latency: wLClk_i rising before clock edge k gives wLEdge high between k+1 and k+2. The FSM acts at k+2.
- Trigger in the same cycle as wLEdge while IDLE: the channel goes to ARM and that edge is not counted.
- Final wLEdge and a trigger in the same cycle while in HOLD:
  - wRetrig_i = 0: the channel exits to IDLE and the trigger counts as a miss.
  - wRetrig_i = 1: ARM wins.
- Window length from acceptance to IDLE: between L and L+1 slow periods, plus up to 3 fast cycles.
- wBusy_o and wMiss_o lag the state by one cycle.

## Configuration
- HWTRIG_MISSCNT_EN defined: the miss counter and wMissClr_i are implemented as described.
- Not defined: no counter logic is generated, wMissCnt_o is tied to 0 and wMissClr_i is ignored. wMiss_o pulses remain.

## Test plan
- Legacy equivalence: NCH=1, L=1, slow reference = fast/8, 1-cycle trigger → wTrig_o high from the trigger cycle until 3 fast cycles after the second wLClk_i rise.
- Length: L=5, trigger on ch2 → wTrig_o[2] falls at the 6th detected slow edge after acceptance; other channels stay 0. L=0 → behaves as L=1.
- Drop mode: wRetrig_i=0, second trigger during HOLD → one-cycle wMiss_o, wMissCnt_o = 1, window end unchanged. Triggers on 3 channels in the same cycle → count += 3.
- Retrigger: wRetrig_i=1, trigger during HOLD with rCnt=2 → back to ARM, window extended by a full L periods, no miss.
- Boundaries:
  - Miss counter preloaded near saturation (MISS_W=4): 20 misses → holds at 15.
  - wMissClr_i together with a miss → 0.
  - Trigger coincident with the final edge behaves as specified for each retrigger mode.
- Reset: wReset_i asserted mid-HOLD → state IDLE with no clock edge, wBusy_o=0. After release, a new trigger is accepted normally.
